vga_scan_fetch: RTL and testbench

Scan-timing and framebuffer-fetch stage directly upstream of the palette/pixel printer. It generates 640x480@60 VGA timing from vgaClk and drives linear read addresses into the 307200-entry colour-index framebuffer. It returns each fetched 8-bit colour_index together with a videoOn that is aligned to it. hsync/vsync are delayed so they line up with the RGB that the pixel printer registers downstream.

---
 rtl/vga_scan_fetch_if.sv | 26 ++
 rtl/vga_scan_fetch.sv | 134 +++++++++++++
 tb/tb_vga_scan_fetch.sv | 357 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_scan_fetch_if.sv
// vga_scan_fetch_if: framebuffer read bus plus the scan outputs toward the pixel printer.
interface vga_scan_fetch_if #(
  parameter int ADDR_W = 19
);
  // Timing contract: the scan is free-running, so there is no valid/ready pair. mem_rdata must
  // carry the word addressed by mem_addr exactly MEM_LATENCY clocks later, and videoOn qualifies
  // color_index in the same clock; enable is sampled every clock.
  logic              enable;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_rdata;
  logic              videoOn;
  logic [7:0]        color_index;
  logic              hsync;
  logic              vsync;
  logic              frame_start;

  modport master (
    input  enable, mem_rdata,
    output mem_addr, videoOn, color_index, hsync, vsync, frame_start
  );

  modport slave (
    output enable, mem_rdata,
    input  mem_addr, videoOn, color_index, hsync, vsync, frame_start
  );
endinterface

// File: rtl/vga_scan_fetch.sv
// vga_scan_fetch: VGA scan counters, linear framebuffer fetch and output alignment.
// Optional macro TEST_PATTERN_EN replaces framebuffer data with ten vertical colour bars.
module vga_scan_fetch #(
  parameter int H_ACTIVE    = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter int ADDR_W      = 19,
  parameter int MEM_LATENCY = 1,
  parameter int OUT_DELAY   = 2,
  parameter bit SYNC_POL    = 1'b0
) (
  input  logic             vgaClk,
  input  logic             rst,
  vga_scan_fetch_if.master bus
);
  localparam int H_TOTAL     = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL     = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int SYNC_STAGES = MEM_LATENCY + 1 + OUT_DELAY;

  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
  localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [ADDR_W-1:0] ADDR_MAX = ADDR_W'(H_ACTIVE * V_ACTIVE - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  logic [9:0]             r_h_cnt;
  logic [9:0]             r_v_cnt;
  logic [ADDR_W-1:0]      r_addr;
  logic [MEM_LATENCY-1:0] r_act_pipe;
  logic [SYNC_STAGES-1:0] r_hs_pipe;
  logic [SYNC_STAGES-1:0] r_vs_pipe;
  logic                   r_video_on;
  logic [7:0]             r_color;

  logic       w_h_wrap;
  logic       w_frame_end;
  logic       w_active;
  logic       w_hs_on;
  logic       w_vs_on;
  logic [7:0] w_pixel;

  assign w_h_wrap    = (r_h_cnt == H_LAST);
  assign w_frame_end = w_h_wrap && (r_v_cnt == V_LAST);
  assign w_active    = bus.enable && (r_h_cnt < H_ACT) && (r_v_cnt < V_ACT);
  assign w_hs_on     = bus.enable && (r_h_cnt >= HS_BEG) && (r_h_cnt < HS_END);
  assign w_vs_on     = bus.enable && (r_v_cnt >= VS_BEG) && (r_v_cnt < VS_END);

  // addr wraps straight after the last visible pixel, so blanking already presents address 0.
  always_ff @(posedge vgaClk or negedge rst) begin
    if (!rst) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
      r_addr  <= '0;
    end else if (!bus.enable) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
      r_addr  <= '0;
    end else begin
      r_h_cnt <= w_h_wrap ? 10'd0 : r_h_cnt + 10'd1;
      if (w_h_wrap) begin
        r_v_cnt <= (r_v_cnt == V_LAST) ? 10'd0 : r_v_cnt + 10'd1;
      end
      if (w_frame_end) begin
        r_addr <= '0;
      end else if (w_active) begin
        r_addr <= (r_addr == ADDR_MAX) ? '0 : r_addr + ADDR_ONE;
      end
    end
  end

  always_ff @(posedge vgaClk or negedge rst) begin
    if (!rst) begin
      r_act_pipe <= '0;
      r_hs_pipe  <= '0;
      r_vs_pipe  <= '0;
      r_video_on <= 1'b0;
      r_color    <= 8'd0;
    end else begin
      r_act_pipe[0] <= w_active;
      for (int i = 1; i < MEM_LATENCY; i++) begin
        r_act_pipe[i] <= r_act_pipe[i-1];
      end
      r_hs_pipe[0] <= w_hs_on;
      r_vs_pipe[0] <= w_vs_on;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_hs_pipe[i] <= r_hs_pipe[i-1];
        r_vs_pipe[i] <= r_vs_pipe[i-1];
      end
      r_video_on <= r_act_pipe[MEM_LATENCY-1];
      r_color    <= r_act_pipe[MEM_LATENCY-1] ? w_pixel : 8'd0;
    end
  end

`ifdef TEST_PATTERN_EN
  // x travels alongside the fetch so each bar lines up with its own pixel slot.
  logic [9:0] r_x_pipe [MEM_LATENCY];
  logic [3:0] w_bar;

  always_ff @(posedge vgaClk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < MEM_LATENCY; i++) begin
        r_x_pipe[i] <= '0;
      end
    end else begin
      r_x_pipe[0] <= r_h_cnt;
      for (int i = 1; i < MEM_LATENCY; i++) begin
        r_x_pipe[i] <= r_x_pipe[i-1];
      end
    end
  end

  assign w_bar   = r_x_pipe[MEM_LATENCY-1][9:6];
  assign w_pixel = {4'd0, (w_bar >= 4'd10) ? w_bar - 4'd10 : w_bar};
`else
  assign w_pixel = bus.mem_rdata;
`endif

  assign bus.mem_addr    = r_addr;
  assign bus.videoOn     = r_video_on;
  assign bus.color_index = r_color;
  assign bus.hsync       = r_hs_pipe[SYNC_STAGES-1] ? SYNC_POL : ~SYNC_POL;
  assign bus.vsync       = r_vs_pipe[SYNC_STAGES-1] ? SYNC_POL : ~SYNC_POL;
  assign bus.frame_start = rst && bus.enable && (r_h_cnt == 10'd0) && (r_v_cnt == 10'd0);
endmodule

// File: tb/tb_vga_scan_fetch.sv
// tb_vga_scan_fetch: full 640x480 timing instance (latency 1) beside a shrunken-frame instance
// (latency 3) so whole frames fit in a short run; both checked against an arithmetic scan model.
module tb_vga_scan_fetch;
  localparam int OD = 2;
  localparam logic [30:0] RST_VEC = {1'b0, 19'd0, 1'b0, 8'd0, 1'b1, 1'b1};

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  vga_scan_fetch_if #(.ADDR_W(19)) if_def ();
  vga_scan_fetch_if #(.ADDR_W(19)) if_sml ();

  vga_scan_fetch #(.MEM_LATENCY(1)) u_def (
    .vgaClk(clk),
    .rst   (rst),
    .bus   (if_def)
  );

  vga_scan_fetch #(
    .H_ACTIVE(64), .H_FP(4), .H_SYNC(8), .H_BP(4),
    .V_ACTIVE(12), .V_FP(2), .V_SYNC(2), .V_BP(3),
    .MEM_LATENCY(3)
  ) u_sml (
    .vgaClk(clk),
    .rst   (rst),
    .bus   (if_sml)
  );

  // Framebuffer models: word at address a is a[7:0], returned after each instance's latency.
  logic [7:0] sml_q1, sml_q2;
  always @(posedge clk) begin
    if_def.mem_rdata <= if_def.mem_addr[7:0];
    sml_q1           <= if_sml.mem_addr[7:0];
    sml_q2           <= sml_q1;
    if_sml.mem_rdata <= sml_q2;
  end

  logic [30:0] obs_def, obs_sml;
  assign obs_def = {if_def.frame_start, if_def.mem_addr, if_def.videoOn, if_def.color_index,
                    if_def.hsync, if_def.vsync};
  assign obs_sml = {if_sml.frame_start, if_sml.mem_addr, if_sml.videoOn, if_sml.color_index,
                    if_sml.hsync, if_sml.vsync};

  // Reference model: scan position n counts clocks from the frame origin; hist[k][d] is the
  // position (or -1 when blanked by enable/reset) seen d clocks ago.
  int t_ha [2] = '{640, 64};
  int t_hfp[2] = '{16, 4};
  int t_hsy[2] = '{96, 8};
  int t_ht [2] = '{800, 80};
  int t_va [2] = '{480, 12};
  int t_vfp[2] = '{10, 2};
  int t_vsy[2] = '{2, 2};
  int t_vt [2] = '{525, 19};
  int t_lat[2] = '{1, 3};

  int cur_n[2];
  int hist[2][8];
  bit en_cur;
  bit in_rst;
  int n_checks = 0;
  int n_fail   = 0;

  function automatic int addr_of(input int k, input int n);
    int h, v, a;
    h = n % t_ht[k];
    v = n / t_ht[k];
    if (v >= t_va[k]) return 0;
    a = v * t_ha[k] + ((h < t_ha[k]) ? h : t_ha[k]);
    return (a == t_ha[k] * t_va[k]) ? 0 : a;
  endfunction

  function automatic bit on_screen(input int k, input int e);
    return (e >= 0) && ((e % t_ht[k]) < t_ha[k]) && ((e / t_ht[k]) < t_va[k]);
  endfunction

  function automatic logic [30:0] exp_vec(input int k);
    int ev, es, h, v, a;
    bit fs, von, hs, vs;
    logic [18:0] ma;
    logic [7:0] col;
    ev  = hist[k][t_lat[k] + 1];
    es  = hist[k][t_lat[k] + 1 + OD];
    fs  = !in_rst && en_cur && (cur_n[k] == 0);
    ma  = 19'(addr_of(k, cur_n[k]));
    von = on_screen(k, ev);
    a   = von ? addr_of(k, ev) : 0;
    col = von ? 8'(a) : 8'd0;
    h   = (es >= 0) ? es % t_ht[k] : 0;
    v   = (es >= 0) ? es / t_ht[k] : 0;
    hs  = (es >= 0) && (h >= t_ha[k] + t_hfp[k]) && (h < t_ha[k] + t_hfp[k] + t_hsy[k]);
    vs  = (es >= 0) && (v >= t_va[k] + t_vfp[k]) && (v < t_va[k] + t_vfp[k] + t_vsy[k]);
    return {fs, ma, von, col, ~hs, ~vs};
  endfunction

  // One clock: advance the model at the edge, apply next inputs 1ns later, return at negedge.
  task automatic tick(input bit en_next, input bit rst_next);
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      cur_n[k] = (in_rst || !en_cur) ? 0 : (cur_n[k] + 1) % (t_ht[k] * t_vt[k]);
      for (int i = 7; i > 0; i--) hist[k][i] = hist[k][i-1];
    end
    #1;
    rst    = rst_next;
    in_rst = !rst_next;
    if_def.enable = en_next;
    if_sml.enable = en_next;
    en_cur = en_next;
    for (int k = 0; k < 2; k++) hist[k][0] = (!in_rst && en_cur) ? cur_n[k] : -1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    n_checks++;
    if (obs_def !== RST_VEC) begin
      n_fail++; $display("FAIL reset_def got %h expected %h", obs_def, RST_VEC);
    end
    n_checks++;
    if (obs_sml !== RST_VEC) begin
      n_fail++; $display("FAIL reset_sml got %h expected %h", obs_sml, RST_VEC);
    end
    tick(1'b0, 1'b1);
    n_checks++;
    if (obs_def !== exp_vec(0)) begin
      n_fail++; $display("FAIL idle_def got %h expected %h", obs_def, exp_vec(0));
    end
    n_checks++;
    if (obs_sml !== exp_vec(1)) begin
      n_fail++; $display("FAIL idle_sml got %h expected %h", obs_sml, exp_vec(1));
    end
  endtask

  task automatic test_default_timing();
    for (int c = 0; c < 1700; c++) begin
      tick(1'b1, 1'b1);
      n_checks++;
      if (obs_def !== exp_vec(0)) begin
        n_fail++; $display("FAIL scan_def c=%0d got %h expected %h", c, obs_def, exp_vec(0));
      end
      n_checks++;
      if (obs_sml !== exp_vec(1)) begin
        n_fail++; $display("FAIL scan_sml c=%0d got %h expected %h", c, obs_sml, exp_vec(1));
      end
      n_checks++;
      if (if_def.hsync !== !(((c % 800) >= 660) && ((c % 800) < 756))) begin
        n_fail++; $display("FAIL hsync_window c=%0d got %b", c, if_def.hsync);
      end
      if (c == 0) begin
        n_checks++;
        if (if_def.frame_start !== 1'b1) begin
          n_fail++; $display("FAIL first_frame_start got %b expected 1", if_def.frame_start);
        end
      end
      if (c == 2 || c == 641 || c == 802) begin
        n_checks++;
        if ({if_def.videoOn, if_def.color_index} !==
            {1'b1, (c == 2) ? 8'h00 : (c == 641) ? 8'h7F : 8'h80}) begin
          n_fail++;
          $display("FAIL pixel_value c=%0d got von=%b col=%h", c, if_def.videoOn,
                   if_def.color_index);
        end
      end
    end
  endtask

  task automatic test_small_frames();
    int pulses = 0;
    int p0 = 0;
    int p1 = 0;
    int von_cnt = 0;
    int max_addr = 0;
    for (int c = 0; c < 5000 && pulses < 2; c++) begin
      tick(1'b1, 1'b1);
      n_checks++;
      if (obs_sml !== exp_vec(1)) begin
        n_fail++; $display("FAIL frame_sml c=%0d got %h expected %h", c, obs_sml, exp_vec(1));
      end
      n_checks++;
      if (obs_def !== exp_vec(0)) begin
        n_fail++; $display("FAIL frame_def c=%0d got %h expected %h", c, obs_def, exp_vec(0));
      end
      if (int'(if_sml.mem_addr) > max_addr) max_addr = int'(if_sml.mem_addr);
      if (if_sml.frame_start === 1'b1) begin
        n_checks++;
        if (if_sml.mem_addr !== 19'd0) begin
          n_fail++; $display("FAIL wrap_addr got %0d expected 0", if_sml.mem_addr);
        end
        if (pulses == 0) p0 = c; else p1 = c;
        pulses++;
      end
      if (pulses == 1 && if_sml.videoOn === 1'b1) von_cnt++;
    end
    n_checks++;
    if (pulses != 2) begin
      n_fail++; $display("FAIL frame_pulses got %0d expected 2 (timeout)", pulses);
    end
    n_checks++;
    if (p1 - p0 != 1520) begin
      n_fail++; $display("FAIL frame_period got %0d expected 1520", p1 - p0);
    end
    n_checks++;
    if (von_cnt != 768) begin
      n_fail++; $display("FAIL visible_count got %0d expected 768", von_cnt);
    end
    n_checks++;
    if (max_addr != 767) begin
      n_fail++; $display("FAIL max_addr got %0d expected 767", max_addr);
    end
  endtask

  task automatic test_enable_drop();
    repeat (4) begin
      int run_len = $urandom_range(30, 500);
      int off_len = $urandom_range(1, 60);
      for (int c = 0; c < run_len; c++) begin
        tick(1'b1, 1'b1);
        n_checks++;
        if (obs_def !== exp_vec(0)) begin
          n_fail++; $display("FAIL run_def got %h expected %h", obs_def, exp_vec(0));
        end
        n_checks++;
        if (obs_sml !== exp_vec(1)) begin
          n_fail++; $display("FAIL run_sml got %h expected %h", obs_sml, exp_vec(1));
        end
      end
      for (int c = 0; c < off_len; c++) begin
        tick(1'b0, 1'b1);
        n_checks++;
        if (obs_def !== exp_vec(0)) begin
          n_fail++; $display("FAIL off_def c=%0d got %h expected %h", c, obs_def, exp_vec(0));
        end
        n_checks++;
        if (obs_sml !== exp_vec(1)) begin
          n_fail++; $display("FAIL off_sml c=%0d got %h expected %h", c, obs_sml, exp_vec(1));
        end
        if (c >= 2) begin
          n_checks++;
          if (if_def.videoOn !== 1'b0) begin
            n_fail++; $display("FAIL drain_von_def c=%0d got %b", c, if_def.videoOn);
          end
        end
        if (c >= 4) begin
          n_checks++;
          if ({if_def.hsync, if_def.vsync, if_sml.videoOn} !== 3'b110) begin
            n_fail++;
            $display("FAIL drain_sync_def c=%0d got hs=%b vs=%b sml_von=%b", c, if_def.hsync,
                     if_def.vsync, if_sml.videoOn);
          end
        end
        if (c >= 6) begin
          n_checks++;
          if ({if_sml.hsync, if_sml.vsync} !== 2'b11) begin
            n_fail++; $display("FAIL drain_sync_sml c=%0d got %b%b", c, if_sml.hsync, if_sml.vsync);
          end
        end
      end
      tick(1'b1, 1'b1);
      n_checks++;
      if ({if_def.frame_start, if_def.mem_addr, if_sml.frame_start, if_sml.mem_addr} !==
          {1'b1, 19'd0, 1'b1, 19'd0}) begin
        n_fail++;
        $display("FAIL reenable got fs=%b addr=%0d / fs=%b addr=%0d", if_def.frame_start,
                 if_def.mem_addr, if_sml.frame_start, if_sml.mem_addr);
      end
    end
  endtask

  task automatic test_reset_midline();
    for (int c = 0; c < 3000 && cur_n[0] != 1100; c++) begin
      tick(1'b1, 1'b1);
      n_checks++;
      if (obs_def !== exp_vec(0)) begin
        n_fail++; $display("FAIL pre_rst_def got %h expected %h", obs_def, exp_vec(0));
      end
    end
    n_checks++;
    if (cur_n[0] != 1100) begin
      n_fail++; $display("FAIL midline_reach got %0d expected 1100 (timeout)", cur_n[0]);
    end
    #2;
    rst    = 1'b0;
    in_rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      cur_n[k] = 0;
      for (int i = 0; i < 8; i++) hist[k][i] = -1;
    end
    #1;
    n_checks++;
    if (obs_def !== RST_VEC) begin
      n_fail++; $display("FAIL async_rst_def got %h expected %h", obs_def, RST_VEC);
    end
    n_checks++;
    if (obs_sml !== RST_VEC) begin
      n_fail++; $display("FAIL async_rst_sml got %h expected %h", obs_sml, RST_VEC);
    end
    repeat (3) tick(1'b1, 1'b0);
    tick(1'b1, 1'b1);
    n_checks++;
    if ({if_def.frame_start, if_def.mem_addr, if_sml.frame_start} !== {1'b1, 19'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL restart got fs=%b addr=%0d sml_fs=%b", if_def.frame_start,
               if_def.mem_addr, if_sml.frame_start);
    end
    for (int c = 0; c < 300; c++) begin
      tick(1'b1, 1'b1);
      n_checks++;
      if (obs_def !== exp_vec(0)) begin
        n_fail++; $display("FAIL post_rst_def c=%0d got %h expected %h", c, obs_def, exp_vec(0));
      end
      n_checks++;
      if (obs_sml !== exp_vec(1)) begin
        n_fail++; $display("FAIL post_rst_sml c=%0d got %h expected %h", c, obs_sml, exp_vec(1));
      end
    end
  endtask

  task automatic test_random_enable();
    for (int c = 0; c < 800; c++) begin
      tick($urandom_range(0, 7) != 0, 1'b1);
      n_checks++;
      if (obs_def !== exp_vec(0)) begin
        n_fail++; $display("FAIL rand_def c=%0d got %h expected %h", c, obs_def, exp_vec(0));
      end
      n_checks++;
      if (obs_sml !== exp_vec(1)) begin
        n_fail++; $display("FAIL rand_sml c=%0d got %h expected %h", c, obs_sml, exp_vec(1));
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    if_def.enable = 1'b0;
    if_sml.enable = 1'b0;
    en_cur = 1'b0;
    in_rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      cur_n[k] = 0;
      for (int i = 0; i < 8; i++) hist[k][i] = -1;
    end
    test_reset();
    test_default_timing();
    test_small_frames();
    test_enable_drop();
    test_reset_midline();
    test_random_enable();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
